// File: rtl/switch_pkt_framer.sv
// switch_pkt_framer
//   Buffers payload bytes from a producer and, on a send command, drives one
//   framed switch packet onto packet_valid/data: DA, LEN, payload bytes,
//   then a parity byte (packet_valid low), followed by an IPG-cycle idle gap.
//
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   pl_wr_en, pl_wr_data - payload byte write into the buffer
//   pl_full, pl_count    - buffer cannot accept a write / bytes buffered
//   send, send_da        - start-packet request and its destination address
//   busy                 - packet or inter-packet gap in progress
//   err_len              - one-cycle pulse: send rejected, buffer empty
//   pkt_sent             - one-cycle pulse on the parity cycle
//   packet_valid, data   - switch input bus
module switch_pkt_framer #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned IPG     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pl_wr_en,
    input  logic [7:0] pl_wr_data,
    output logic       pl_full,
    output logic [7:0] pl_count,
    input  logic       send,
    input  logic [7:0] send_da,
    output logic       busy,
    output logic       err_len,
    output logic       pkt_sent,
    output logic       packet_valid,
    output logic [7:0] data
);

    localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [3:0]  IPG_LAST  = 4'(IPG - 1);

    // state_q names the byte currently on the bus (outputs are registered
    // alongside the state, so each state's bus value is computed on entry).
    typedef enum logic [2:0] {
        S_IDLE,
        S_DA,
        S_LEN,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] buf_q [MAX_LEN];
    logic [7:0] buf_d [MAX_LEN];
    logic [7:0] count_q, count_d;
    logic [7:0] len_q, len_d;
    logic [7:0] rd_q, rd_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       pv_q, pv_d;
    logic       busy_q, busy_d;
    logic       full_q, full_d;
    logic       err_q, err_d;
    logic       sent_q, sent_d;

    logic          send_ok;
    logic          wr_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    always_comb begin
        send_ok = (state_q == S_IDLE) && send && (count_q != 8'd0);
        // An accepted send wins over a same-cycle write so LEN is stable.
        wr_ok   = pl_wr_en && !full_q && !send_ok;
        wr_idx  = count_q[AW-1:0];
        rd_idx  = rd_q[AW-1:0];

        buf_d    = buf_q;
        count_d  = count_q;
        state_d  = state_q;
        len_d    = len_q;
        rd_d     = rd_q;
        gap_d    = gap_q;
        parity_d = parity_q;
        data_d   = '0;
        pv_d     = 1'b0;
        err_d    = 1'b0;
        sent_d   = 1'b0;

        if (wr_ok) begin
            buf_d[wr_idx] = pl_wr_data;
            count_d       = count_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                parity_d = '0;
                if (send) begin
                    if (send_ok) begin
                        state_d  = S_DA;
                        len_d    = count_q;
                        data_d   = send_da;
                        pv_d     = 1'b1;
                        parity_d = send_da;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DA: begin
                state_d  = S_LEN;
                data_d   = len_q;
                pv_d     = 1'b1;
                parity_d = parity_q ^ len_q;
                rd_d     = '0;
            end
            S_LEN, S_PAYLOAD: begin
                // LEN always has at least one payload byte to follow.
                if (state_q == S_LEN || rd_q != len_q) begin
                    state_d  = S_PAYLOAD;
                    data_d   = buf_q[rd_idx];
                    pv_d     = 1'b1;
                    parity_d = parity_q ^ buf_q[rd_idx];
                    rd_d     = rd_q + 8'd1;
                end else begin
                    state_d = S_PARITY;
                    data_d  = parity_q;
                    sent_d  = 1'b1;
                    count_d = '0;
                end
            end
            S_PARITY: begin
                state_d = S_GAP;
                gap_d   = '0;
            end
            S_GAP: begin
                if (gap_q == IPG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        full_d = (count_d == MAX_LEN_B) || busy_d;
    end

    always_ff @(posedge clock) begin
        // Buffer contents need no reset: pl_count=0 makes them unreachable.
        buf_q <= buf_d;
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            len_q    <= '0;
            rd_q     <= '0;
            gap_q    <= '0;
            parity_q <= '0;
            data_q   <= '0;
            pv_q     <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            rd_q     <= rd_d;
            gap_q    <= gap_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            pv_q     <= pv_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            err_q    <= err_d;
            sent_q   <= sent_d;
        end
    end

    assign pl_full      = full_q;
    assign pl_count     = count_q;
    assign busy         = busy_q;
    assign err_len      = err_q;
    assign pkt_sent     = sent_q;
    assign packet_valid = pv_q;
    assign data         = data_q;

endmodule

// File: tb/tb_switch_pkt_framer.sv
// tb_switch_pkt_framer
//   Directed bench for switch_pkt_framer (MAX_LEN=64, IPG=2). Inputs are
//   driven 1 time unit after each rising edge; outputs are sampled at the
//   same point, i.e. they show the state loaded by that edge.
module tb_switch_pkt_framer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pl_wr_en;
    logic [7:0] pl_wr_data;
    logic       pl_full;
    logic [7:0] pl_count;
    logic       send;
    logic [7:0] send_da;
    logic       busy;
    logic       err_len;
    logic       pkt_sent;
    logic       packet_valid;
    logic [7:0] data;

    int n_assert = 0;
    int n_fail   = 0;

    switch_pkt_framer #(
        .MAX_LEN(64),
        .IPG    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pl_wr_en    (pl_wr_en),
        .pl_wr_data  (pl_wr_data),
        .pl_full     (pl_full),
        .pl_count    (pl_count),
        .send        (send),
        .send_da     (send_da),
        .busy        (busy),
        .err_len     (err_len),
        .pkt_sent    (pkt_sent),
        .packet_valid(packet_valid),
        .data        (data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic pv, input logic [7:0] d);
        chk({tag, ".pv"}, 32'(packet_valid), 32'(pv));
        chk({tag, ".data"}, 32'(data), 32'(d));
    endtask

    task automatic wr_byte(input logic [7:0] b);
        pl_wr_en   = 1'b1;
        pl_wr_data = b;
        tick();
        pl_wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pl_wr_en = 1'b0; pl_wr_data = '0; send = 1'b0; send_da = '0;
        tick(); tick();

        // Reset state
        chk("rst.pv", 32'(packet_valid), 32'd0);
        chk("rst.data", 32'(data), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.full", 32'(pl_full), 32'd0);
        chk("rst.count", 32'(pl_count), 32'd0);
        chk("rst.err", 32'(err_len), 32'd0);
        chk("rst.sent", 32'(pkt_sent), 32'd0);
        reset = 1'b0;
        tick();

        // Basic 3-byte packet
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        chk("t1.count", 32'(pl_count), 32'd3);
        send = 1'b1; send_da = 8'h01;
        tick();
        send = 1'b0;
        chk_bus("t1.da", 1'b1, 8'h01);
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.full_busy", 32'(pl_full), 32'd1);
        tick(); chk_bus("t1.len", 1'b1, 8'h03);
        tick(); chk_bus("t1.p0", 1'b1, 8'h11);
        tick(); chk_bus("t1.p1", 1'b1, 8'h22);
        tick(); chk_bus("t1.p2", 1'b1, 8'h33);
        tick(); chk_bus("t1.par", 1'b0, 8'h02);
        chk("t1.sent", 32'(pkt_sent), 32'd1);
        chk("t1.count0", 32'(pl_count), 32'd0);
        tick(); chk_bus("t1.gap0", 1'b0, 8'h00);
        chk("t1.sent_off", 32'(pkt_sent), 32'd0);
        chk("t1.gap0.busy", 32'(busy), 32'd1);
        tick(); chk_bus("t1.gap1", 1'b0, 8'h00);
        chk("t1.gap1.busy", 32'(busy), 32'd1);
        tick();
        chk("t1.idle.busy", 32'(busy), 32'd0);
        chk("t1.idle.full", 32'(pl_full), 32'd0);

        // Send with empty buffer
        send = 1'b1; send_da = 8'h55;
        tick();
        send = 1'b0;
        chk("t2.err", 32'(err_len), 32'd1);
        chk("t2.busy", 32'(busy), 32'd0);
        chk_bus("t2.bus", 1'b0, 8'h00);
        tick();
        chk("t2.err_off", 32'(err_len), 32'd0);
        chk_bus("t2.bus2", 1'b0, 8'h00);

        // Fill to MAX_LEN, overflow write dropped, full-length packet
        for (int i = 0; i < 64; i++) wr_byte(8'(i));
        chk("t3.full", 32'(pl_full), 32'd1);
        chk("t3.count", 32'(pl_count), 32'd64);
        wr_byte(8'hAA);
        chk("t3.count_ovf", 32'(pl_count), 32'd64);
        send = 1'b1; send_da = 8'h02;
        tick();
        send = 1'b0;
        chk_bus("t3.da", 1'b1, 8'h02);
        tick(); chk_bus("t3.len", 1'b1, 8'h40);
        for (int i = 0; i < 64; i++) begin
            tick();
            chk_bus($sformatf("t3.p%0d", i), 1'b1, 8'(i));
        end
        tick(); chk_bus("t3.par", 1'b0, 8'h42);
        chk("t3.sent", 32'(pkt_sent), 32'd1);
        tick(); tick(); tick();
        chk("t3.idle", 32'(busy), 32'd0);

        // Send and write in same cycle; writes and send ignored while busy
        wr_byte(8'h5A); wr_byte(8'hA5);
        send = 1'b1; send_da = 8'h03; pl_wr_en = 1'b1; pl_wr_data = 8'h77;
        tick();
        chk_bus("t4.da", 1'b1, 8'h03);
        chk("t4.count", 32'(pl_count), 32'd2);
        send_da = 8'h44; pl_wr_data = 8'h99;
        tick(); chk_bus("t4.len", 1'b1, 8'h02);
        chk("t4.count_busy", 32'(pl_count), 32'd2);
        chk("t4.err", 32'(err_len), 32'd0);
        tick(); chk_bus("t4.p0", 1'b1, 8'h5A);
        tick(); chk_bus("t4.p1", 1'b1, 8'hA5);
        send = 1'b0; pl_wr_en = 1'b0;
        tick(); chk_bus("t4.par", 1'b0, 8'hFE);
        chk("t4.err2", 32'(err_len), 32'd0);
        tick(); tick(); tick();
        chk("t4.idle", 32'(busy), 32'd0);
        chk("t4.count_end", 32'(pl_count), 32'd0);

        // Reset mid-payload, then a 1-byte packet
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        send = 1'b1; send_da = 8'h10;
        tick();
        send = 1'b0;
        chk_bus("t5.da", 1'b1, 8'h10);
        tick(); chk_bus("t5.len", 1'b1, 8'h05);
        tick(); chk_bus("t5.p0", 1'b1, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_bus("t5.rst", 1'b0, 8'h00);
        chk("t5.rst.count", 32'(pl_count), 32'd0);
        chk("t5.rst.busy", 32'(busy), 32'd0);
        tick();
        chk_bus("t5.after", 1'b0, 8'h00);
        wr_byte(8'hC3);
        send = 1'b1; send_da = 8'h07;
        tick();
        chk_bus("t5.da2", 1'b1, 8'h07);
        // Hold send through the packet and gap: it must be ignored while busy.
        tick(); chk_bus("t5.len2", 1'b1, 8'h01);
        tick(); chk_bus("t5.p2", 1'b1, 8'hC3);
        tick(); chk_bus("t5.par2", 1'b0, 8'hC5);
        chk("t5.sent", 32'(pkt_sent), 32'd1);

        // Gap timing and first send after the gap
        send_da = 8'h08;
        tick(); chk_bus("t6.gap0", 1'b0, 8'h00);
        chk("t6.gap0.busy", 32'(busy), 32'd1);
        chk("t6.gap0.err", 32'(err_len), 32'd0);
        tick(); chk_bus("t6.gap1", 1'b0, 8'h00);
        chk("t6.gap1.busy", 32'(busy), 32'd1);
        tick();
        chk("t6.idle.busy", 32'(busy), 32'd0);
        chk("t6.idle.err", 32'(err_len), 32'd0);
        // Empty buffer: held send is rejected, same-cycle write is taken.
        pl_wr_en = 1'b1; pl_wr_data = 8'h3C;
        tick();
        pl_wr_en = 1'b0;
        chk("t6.err", 32'(err_len), 32'd1);
        chk("t6.count", 32'(pl_count), 32'd1);
        tick();
        send = 1'b0;
        chk_bus("t6.da", 1'b1, 8'h08);
        chk("t6.err_off", 32'(err_len), 32'd0);
        tick(); chk_bus("t6.len", 1'b1, 8'h01);
        tick(); chk_bus("t6.p0", 1'b1, 8'h3C);
        tick(); chk_bus("t6.par", 1'b0, 8'h35);
        tick(); tick(); tick();
        chk("t6.end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
